// File: rtl/fat_enc_pkg.sv
// fat_enc_pkg: shared helpers for the pipelined fat-tree encoder.
// Tree geometry, partial widths and bus offsets for every level.
package fat_enc_pkg;

  localparam int N_MIN = 16;
  localparam int N_MAX = 1024;

  function automatic int log4(input int n);
    int l;
    l = 0;
    for (int v = n; v > 1; v = v / 4) l++;
    return l;
  endfunction

  // width of one group's count at a level (holds 0..4**lvl)
  function automatic int part_w(input int lvl);
    return 2 * lvl + 1;
  endfunction

  function automatic int grp_n(input int n, input int lvl);
    return n >> (2 * lvl);
  endfunction

  // bit offset of a level's counts in the flattened count bus
  function automatic int cnt_off(input int n, input int lvl);
    int s;
    s = 0;
    for (int k = 0; k < lvl; k++)
      s += grp_n(n, k) * part_w(k);
    return s;
  endfunction

  // bit offset of a level's full/empty bits in their buses
  function automatic int fe_off(input int n, input int lvl);
    int s;
    s = 0;
    for (int k = 0; k < lvl; k++)
      s += grp_n(n, k);
    return s;
  endfunction

  function automatic bit n_in_ok(input int n);
    return (n >= N_MIN) && (n <= N_MAX) &&
           ((1 << (2 * log4(n))) == n);
  endfunction

  function automatic int cw_of(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fat_enc_stage.sv
// fat_enc_stage: one registered 4:1 fat-tree combine level.
// Sums four group counts and ANDs their full/empty bits.
module fat_enc_stage
  import fat_enc_pkg::*;
#(
  parameter int G  = 1,
  parameter int PW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_v,
  input  logic                  i_bub,
  input  logic [4*G*PW-1:0]     i_cnt,
  input  logic [4*G-1:0]        i_full,
  input  logic [4*G-1:0]        i_empty,
  output logic                  o_v,
  output logic                  o_bub,
  output logic [G*(PW+2)-1:0]   o_cnt,
  output logic [G-1:0]          o_full,
  output logic [G-1:0]          o_empty
);

  localparam int OW = PW + 2;

  logic [G*OW-1:0] w_cnt;
  logic [G-1:0]    w_full;
  logic [G-1:0]    w_empty;

  logic            r_v;
  logic            r_bub;
  logic [G*OW-1:0] r_cnt;
  logic [G-1:0]    r_full;
  logic [G-1:0]    r_empty;

  // combine each group of four children into one parent
  always_comb begin
    w_cnt   = '0;
    w_full  = '0;
    w_empty = '0;
    for (int g = 0; g < G; g++) begin
      w_cnt[g*OW +: OW] =
        OW'(i_cnt[(4*g+0)*PW +: PW]) +
        OW'(i_cnt[(4*g+1)*PW +: PW]) +
        OW'(i_cnt[(4*g+2)*PW +: PW]) +
        OW'(i_cnt[(4*g+3)*PW +: PW]);
      w_full[g]  = &i_full[4*g +: 4];
      w_empty[g] = &i_empty[4*g +: 4];
    end
  end

  // level register; data only moves with a valid sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v     <= 1'b0;
      r_bub   <= 1'b0;
      r_cnt   <= '0;
      r_full  <= '0;
      r_empty <= '0;
    end else begin
      r_v <= i_v;
      if (i_v) begin
        r_bub   <= i_bub;
        r_cnt   <= w_cnt;
        r_full  <= w_full;
        r_empty <= w_empty;
      end
    end
  end

  assign o_v     = r_v;
  assign o_bub   = r_bub;
  assign o_cnt   = r_cnt;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/fat_tree_enc_pipe.sv
// fat_tree_enc_pipe: pipelined thermometer-to-binary encoder.
// Bubble corrector, one rank per 4:1 level, flags, peak hold.
module fat_tree_enc_pipe
  import fat_enc_pkg::*;
#(
  parameter int N_IN      = 64,
  parameter bit BUBBLE_EN = 1'b1,
  parameter int CW        = $clog2(N_IN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [N_IN-1:0] data_in,
  input  logic            peak_clr,
  output logic            valid_out,
  output logic [CW-1:0]   code_out,
  output logic            all_zero,
  output logic            all_one,
  output logic            bubble_err,
  output logic [CW-1:0]   peak_code
);

  localparam int LEVELS = log4(N_IN);
  localparam int CB     = cnt_off(N_IN, LEVELS + 1);
  localparam int FB     = fe_off(N_IN, LEVELS + 1);
  localparam int PP     = part_w(LEVELS - 1);
  localparam int PO     = cnt_off(N_IN, LEVELS - 1);
  localparam int LO     = cnt_off(N_IN, LEVELS);
  localparam int LF     = fe_off(N_IN, LEVELS);

  if (!n_in_ok(N_IN) || CW != cw_of(N_IN) ||
      CW != part_w(LEVELS)) begin : g_bad_cfg
    $error("fat_tree_enc_pipe: bad N_IN/CW");
  end

  logic [N_IN-1:0] r_t;
  logic            r_v0;
  logic [N_IN-1:0] w_c;
  logic            w_bub0;

  logic [CB-1:0]   w_cnt;
  logic [FB-1:0]   w_full;
  logic [FB-1:0]   w_empty;
  logic [LEVELS:0] w_v;
  logic [LEVELS:0] w_bub;

  logic [CW-1:0]   w_pk_c;
  logic            w_pk_v;
  logic [CW-1:0]   r_peak;

  // input rank: capture the sampler word on valid cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t  <= '0;
      r_v0 <= 1'b0;
    end else begin
      r_v0 <= valid_in;
      if (valid_in) r_t <= data_in;
    end
  end

  if (BUBBLE_EN) begin : g_bub
    logic [N_IN+1:0] w_ext;
    logic [N_IN-1:0] w_maj;

    // ones below bit 0, zeros above the top bit
    assign w_ext = {1'b0, r_t, 1'b1};

    // 3-tap majority vote around every bit
    always_comb begin
      w_maj = '0;
      for (int i = 0; i < N_IN; i++)
        w_maj[i] = (w_ext[i]   & w_ext[i+1]) |
                   (w_ext[i]   & w_ext[i+2]) |
                   (w_ext[i+1] & w_ext[i+2]);
    end

    assign w_c    = w_maj;
    assign w_bub0 = (w_maj != r_t);
  end else begin : g_byp
    assign w_c    = r_t;
    assign w_bub0 = 1'b0;
  end

  // leaves: every corrected bit is a one-bit group
  assign w_cnt[N_IN-1:0]   = w_c;
  assign w_full[N_IN-1:0]  = w_c;
  assign w_empty[N_IN-1:0] = ~w_c;
  assign w_v[0]            = r_v0;
  assign w_bub[0]          = w_bub0;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int GI = grp_n(N_IN, l - 1);
    localparam int GO = grp_n(N_IN, l);
    localparam int PI = part_w(l - 1);
    localparam int PL = part_w(l);
    localparam int CI = cnt_off(N_IN, l - 1);
    localparam int CO = cnt_off(N_IN, l);
    localparam int FI = fe_off(N_IN, l - 1);
    localparam int FO = fe_off(N_IN, l);

    fat_enc_stage #(
      .G  (GO),
      .PW (PI)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_v     (w_v[l-1]),
      .i_bub   (w_bub[l-1]),
      .i_cnt   (w_cnt[CI +: GI*PI]),
      .i_full  (w_full[FI +: GI]),
      .i_empty (w_empty[FI +: GI]),
      .o_v     (w_v[l]),
      .o_bub   (w_bub[l]),
      .o_cnt   (w_cnt[CO +: GO*PL]),
      .o_full  (w_full[FO +: GO]),
      .o_empty (w_empty[FO +: GO])
    );
  end

  // the count the last level is about to load, for peak hold
  assign w_pk_c = CW'(w_cnt[PO + 0*PP +: PP]) +
                  CW'(w_cnt[PO + 1*PP +: PP]) +
                  CW'(w_cnt[PO + 2*PP +: PP]) +
                  CW'(w_cnt[PO + 3*PP +: PP]);
  assign w_pk_v = w_v[LEVELS-1];

  // peak hold: clear wins and seeds from a coincident sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
    end else if (peak_clr) begin
      r_peak <= w_pk_v ? w_pk_c : '0;
    end else if (w_pk_v && (w_pk_c > r_peak)) begin
      r_peak <= w_pk_c;
    end
  end

  assign valid_out  = w_v[LEVELS];
  assign bubble_err = w_bub[LEVELS];
  assign code_out   = w_cnt[LO +: CW];
  assign all_one    = w_full[LF];
  assign all_zero   = w_empty[LF];
  assign peak_code  = r_peak;

endmodule

// File: tb/tb_fat_tree_enc_pipe.sv
// tb_fat_tree_enc_pipe: random and directed checks of four configs
// against a behavioural popcount / majority / peak model.
module tb_fat_tree_enc_pipe;

  localparam int ND   = 4;
  localparam int HMAX = 4096;

  logic         clk;
  logic         rst;
  logic         vin;
  logic [255:0] din;
  logic         pclr;

  logic       vo_a, az_a, ao_a, be_a;
  logic [6:0] co_a, pk_a;
  logic       vo_b, az_b, ao_b, be_b;
  logic [6:0] co_b, pk_b;
  logic       vo_c, az_c, ao_c, be_c;
  logic [4:0] co_c, pk_c;
  logic       vo_d, az_d, ao_d, be_d;
  logic [8:0] co_d, pk_d;

  int ov[ND], oc[ND], oaz[ND], oao[ND], obe[ND], opk[ND];

  int dn[ND]  = '{64, 64, 16, 256};
  bit dbe[ND] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int dlat[ND] = '{4, 4, 3, 5};

  int m_v[ND], m_code[ND], m_az[ND], m_ao[ND];
  int m_be[ND], m_pk[ND];

  logic         hv [HMAX];
  logic [255:0] hd [HMAX];
  logic         hpc[HMAX];
  int ecnt;
  int rst_edge;

  int checks;
  int errors;

  fat_tree_enc_pipe #(.N_IN(64), .BUBBLE_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .valid_in(vin),
    .data_in(din[63:0]), .peak_clr(pclr),
    .valid_out(vo_a), .code_out(co_a), .all_zero(az_a),
    .all_one(ao_a), .bubble_err(be_a), .peak_code(pk_a)
  );

  fat_tree_enc_pipe #(.N_IN(64), .BUBBLE_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .valid_in(vin),
    .data_in(din[63:0]), .peak_clr(pclr),
    .valid_out(vo_b), .code_out(co_b), .all_zero(az_b),
    .all_one(ao_b), .bubble_err(be_b), .peak_code(pk_b)
  );

  fat_tree_enc_pipe #(.N_IN(16), .BUBBLE_EN(1'b1)) u_c (
    .clk(clk), .rst(rst), .valid_in(vin),
    .data_in(din[15:0]), .peak_clr(pclr),
    .valid_out(vo_c), .code_out(co_c), .all_zero(az_c),
    .all_one(ao_c), .bubble_err(be_c), .peak_code(pk_c)
  );

  fat_tree_enc_pipe #(.N_IN(256), .BUBBLE_EN(1'b1)) u_d (
    .clk(clk), .rst(rst), .valid_in(vin),
    .data_in(din), .peak_clr(pclr),
    .valid_out(vo_d), .code_out(co_d), .all_zero(az_d),
    .all_one(ao_d), .bubble_err(be_d), .peak_code(pk_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ov[0] = int'(vo_a); oc[0] = int'(co_a); oaz[0] = int'(az_a);
    oao[0] = int'(ao_a); obe[0] = int'(be_a); opk[0] = int'(pk_a);
    ov[1] = int'(vo_b); oc[1] = int'(co_b); oaz[1] = int'(az_b);
    oao[1] = int'(ao_b); obe[1] = int'(be_b); opk[1] = int'(pk_b);
    ov[2] = int'(vo_c); oc[2] = int'(co_c); oaz[2] = int'(az_c);
    oao[2] = int'(ao_c); obe[2] = int'(be_c); opk[2] = int'(pk_c);
    ov[3] = int'(vo_d); oc[3] = int'(co_d); oaz[3] = int'(az_d);
    oao[3] = int'(ao_d); obe[3] = int'(be_d); opk[3] = int'(pk_d);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] therm(input int k);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      if (i < k) r[i] = 1'b1;
    return r;
  endfunction

  // popcount of the majority-corrected word, and whether it changed
  task automatic ref_word(input int n, input bit be,
                          input logic [255:0] d,
                          output int pop, output int bub);
    int tm, t0, tp, c;
    pop = 0;
    bub = 0;
    for (int i = 0; i < n; i++) begin
      tm = (i == 0)     ? 1 : int'(d[i-1]);
      t0 = int'(d[i]);
      tp = (i == n - 1) ? 0 : int'(d[i+1]);
      c  = be ? (((tm + t0 + tp) >= 2) ? 1 : 0) : t0;
      pop += c;
      if (c != t0) bub = 1;
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < ND; j++) begin
      m_v[j] = 0; m_code[j] = 0; m_az[j] = 0;
      m_ao[j] = 0; m_be[j] = 0; m_pk[j] = 0;
    end
  endtask

  // output-side view of edge e: the sample from lat-1 edges earlier
  task automatic model_edge(input int j, input int e);
    int idx, v, pop, bub;
    idx = e - (dlat[j] - 1);
    v = (idx >= rst_edge) ? int'(hv[idx]) : 0;
    pop = 0;
    bub = 0;
    if (v != 0) ref_word(dn[j], dbe[j], hd[idx], pop, bub);
    m_v[j] = v;
    if (v != 0) begin
      m_code[j] = pop;
      m_az[j]   = (pop == 0) ? 1 : 0;
      m_ao[j]   = (pop == dn[j]) ? 1 : 0;
      m_be[j]   = bub;
    end
    if (hpc[e])
      m_pk[j] = (v != 0) ? pop : 0;
    else if (v != 0 && pop > m_pk[j])
      m_pk[j] = pop;
  endtask

  task automatic check_all();
    for (int j = 0; j < ND; j++) begin
      chk($sformatf("valid%0d", j), ov[j], m_v[j]);
      chk($sformatf("code%0d", j), oc[j], m_code[j]);
      chk($sformatf("zero%0d", j), oaz[j], m_az[j]);
      chk($sformatf("one%0d", j), oao[j], m_ao[j]);
      chk($sformatf("bub%0d", j), obe[j], m_be[j]);
      chk($sformatf("peak%0d", j), opk[j], m_pk[j]);
    end
  endtask

  // drive at the falling edge, model the rising edge, check after it
  task automatic cyc(input logic v, input logic [255:0] d,
                     input logic pc);
    vin  = v;
    din  = d;
    pclr = pc;
    @(posedge clk);
    hv[ecnt]  = v;
    hd[ecnt]  = d;
    hpc[ecnt] = pc;
    for (int j = 0; j < ND; j++) model_edge(j, ecnt);
    ecnt++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 256'(i * 37), 1'b0);
  endtask

  // asynchronous pulse between edges; outputs must clear at once
  task automatic async_reset();
    vin  = 1'b0;
    pclr = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_clear();
    check_all();
    #1 rst = 1'b0;
    rst_edge = ecnt;
  endtask

  initial begin
    logic [255:0] d;
    checks = 0;
    errors = 0;
    ecnt = 0;
    rst_edge = 0;
    rst = 1'b1;
    vin = 1'b0;
    din = '0;
    pclr = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // clean sweep 0..64
    for (int k = 0; k <= 64; k++) cyc(1'b1, therm(k), 1'b0);
    idle(6);
    chk("sweep_peak64", opk[0], 64);
    chk("sweep_peak16", opk[2], 16);

    // single bubble at bit 3
    d = '0;
    d[7:0] = 8'hF7;
    cyc(1'b1, d, 1'b0);
    idle(6);
    chk("bubble_code_en", oc[0], 8);
    chk("bubble_flag_en", obe[0], 1);
    chk("bubble_code_dis", oc[1], 7);
    chk("bubble_flag_dis", obe[1], 0);

    // valid gaps
    cyc(1'b1, therm(10), 1'b0);
    cyc(1'b0, therm(50), 1'b0);
    cyc(1'b0, therm(3), 1'b0);
    cyc(1'b1, therm(20), 1'b0);
    idle(6);

    // peak hold, clear on an idle cycle first
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, therm(30), 1'b0);
    cyc(1'b1, therm(50), 1'b0);
    cyc(1'b1, therm(40), 1'b0);
    cyc(1'b1, therm(12), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, therm(5), 1'b1);
    idle(6);
    chk("peak_seeded", opk[0], 12);
    cyc(1'b0, '0, 1'b1);
    chk("peak_idle_clr", opk[0], 0);

    // reset with samples in flight
    cyc(1'b1, therm(33), 1'b0);
    cyc(1'b1, therm(44), 1'b0);
    cyc(1'b1, therm(55), 1'b0);
    async_reset();
    idle(2);
    cyc(1'b1, therm(9), 1'b0);
    idle(6);

    // full-scale on every width
    cyc(1'b1, '1, 1'b0);
    idle(6);
    chk("full256_code", oc[3], 256);
    chk("full256_one", oao[3], 1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic v, pc;
      int k;
      v = ($urandom_range(0, 3) != 0);
      pc = ($urandom_range(0, 15) == 0);
      k = $urandom_range(0, 256);
      d = therm(k);
      if ($urandom_range(0, 2) == 0)
        d[$urandom_range(0, 255)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0)
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom();
      if ($urandom_range(0, 7) == 0)
        d = therm($urandom_range(0, 16));
      cyc(v, d, pc);
      if (n == 200) async_reset();
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
